// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Data-memory access controller for the Memory stage. Turns the stage's
// load/store into a single-outstanding req/gnt/rvalid bus transaction,
// aligns store byte lanes and load data, and raises dmem_stall_o so the
// hazard unit freezes the pipeline while an access is in flight.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses are not issued; misalign_o=1
//   undefined : misalign_o=0, offending low address bits are ignored
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mem_valid_i                  Memory-stage instruction valid
//   mem_read_i, mem_write_i      load / store (both high => load)
//   mem_size_i                   00 byte, 01 half, 10/11 word
//   mem_unsigned_i               zero-extend loads
//   mem_addr_i, mem_wdata_i      byte address, LSB-justified store data
//   dmem_req_o .. dmem_wdata_o   bus request (all zero while req=0)
//   dmem_gnt_i, dmem_rvalid_i,
//   dmem_rdata_i                 bus response
//   load_data_o                  aligned/extended load result (registered)
//   dmem_stall_o                 access not yet complete
//   misalign_o                   misaligned access trapped
// ---------------------------------------------------------------------------
module dmem_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] load_data_o,
    output logic        dmem_stall_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t      r_state;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_unsigned;
    logic [31:0] r_load_data;

    logic        w_access;
    logic        w_misalign;
    logic        w_go;
    logic        w_we;
    logic [1:0]  w_lane;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Extract the addressed byte/half from the bus word and extend it.
    function automatic logic [31:0] f_extract(input logic [31:0] d,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = lane[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = d;
        endcase
        return res;
    endfunction

    // Reset also suppresses a request so nothing leaks onto the bus while
    // the pipeline is being flushed.
    assign w_access = mem_valid_i & (mem_read_i | mem_write_i) & ~rst_i;
    assign w_we     = mem_write_i & ~mem_read_i;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = w_access && (r_state == IDLE) &&
                        (((mem_size_i == 2'b01) && mem_addr_i[0]) ||
                         (mem_size_i[1] && (mem_addr_i[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_go = w_access & ~w_misalign;

    // Lane after alignment: halves snap to a[1], words to lane 0.
    always_comb begin
        w_lane  = 2'b00;
        w_be    = 4'b1111;
        w_wdata = mem_wdata_i;
        case (mem_size_i)
            2'b00: begin
                w_lane  = mem_addr_i[1:0];
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                w_lane  = {mem_addr_i[1], 1'b0};
                w_be    = 4'b0011 << w_lane;
                w_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                w_lane  = 2'b00;
                w_be    = 4'b1111;
                w_wdata = mem_wdata_i;
            end
        endcase
    end

    // Bus request: straight from the inputs in IDLE, from the holding
    // register in REQ so fields stay stable until granted.
    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0000;
        dmem_addr_o  = 32'd0;
        dmem_wdata_o = 32'd0;
        dmem_stall_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = w_we;
                    dmem_be_o    = w_be;
                    dmem_addr_o  = {mem_addr_i[31:2], 2'b00};
                    dmem_wdata_o = w_we ? w_wdata : 32'd0;
                    dmem_stall_o = 1'b1;
                end
            end
            REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = r_we;
                dmem_be_o    = r_be;
                dmem_addr_o  = r_addr;
                dmem_wdata_o = r_wdata;
                dmem_stall_o = 1'b1;
            end
            RESP:    dmem_stall_o = 1'b1;
            default: dmem_stall_o = 1'b0;
        endcase
    end

    assign misalign_o  = w_misalign;
    assign load_data_o = r_load_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_be        <= 4'b0000;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_size      <= 2'b00;
            r_lane      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_we       <= w_we;
                        r_be       <= w_be;
                        r_addr     <= {mem_addr_i[31:2], 2'b00};
                        r_wdata    <= w_we ? w_wdata : 32'd0;
                        r_size     <= mem_size_i;
                        r_lane     <= mem_addr_i[1:0];
                        r_unsigned <= mem_unsigned_i;
                        if (dmem_gnt_i) r_state <= w_we ? DONE : RESP;
                        else            r_state <= REQ;
                    end
                end
                // An rvalid coinciding with gnt here belongs to no request.
                REQ: begin
                    if (dmem_gnt_i) r_state <= r_we ? DONE : RESP;
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        r_load_data <= f_extract(dmem_rdata_i, r_size,
                                                 r_lane, r_unsigned);
                        r_state     <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic [31:0] load_data;
    logic        stall, misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .mem_valid_i(mem_valid), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .mem_size_i(mem_size), .mem_unsigned_i(mem_unsigned),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_be_o(be),
        .dmem_addr_o(addr), .dmem_wdata_o(wdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .load_data_o(load_data), .dmem_stall_o(stall), .misalign_o(misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before checking.
    task automatic settle;
        #2;
    endtask

    task automatic idle_inputs;
        mem_valid = 0; mem_read = 0; mem_write = 0; mem_unsigned = 0;
        mem_size = 2'b00; mem_addr = 0; mem_wdata = 0;
        gnt = 0; rvalid = 0; rdata = 0;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        mem_valid = 1; mem_read = 1; mem_write = 0;
        mem_addr = a; mem_size = sz; mem_unsigned = uns; mem_wdata = 0;
    endtask

    // Load with immediate grant and rvalid the following cycle.
    task automatic quick_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                              input logic uns, input logic [31:0] rd, input logic [31:0] exp);
        set_load(a, sz, uns);
        gnt = 1; rvalid = 0;
        tick;                               // -> RESP
        gnt = 0; rvalid = 1; rdata = rd;
        tick;                               // -> DONE
        rvalid = 0; settle;
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_data"}, load_data, exp);
        tick;                               // -> IDLE
        idle_inputs;
    endtask

    initial begin
        idle_inputs;
        rst = 1;
        tick; tick;
        // Reset with an access presented: nothing may go out.
        set_load(32'h0000_2000, 2'b10, 0);
        settle;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_be", {28'd0, be}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        tick;
        idle_inputs;
        rst = 0;
        tick;

        // Store byte 0x1003 / 0xAB, immediate grant
        mem_valid = 1; mem_write = 1; mem_read = 0; mem_size = 2'b00;
        mem_addr = 32'h0000_1003; mem_wdata = 32'h0000_00AB; gnt = 1;
        settle;
        chk("sb_req", {31'd0, req}, 32'd1);
        chk("sb_we", {31'd0, we}, 32'd1);
        chk("sb_addr", addr, 32'h0000_1000);
        chk("sb_be", {28'd0, be}, 32'h8);
        chk("sb_wdata", wdata, 32'hABAB_ABAB);
        chk("sb_stall", {31'd0, stall}, 32'd1);
        tick;                               // -> DONE
        gnt = 0; settle;
        chk("sb_done_req", {31'd0, req}, 32'd0);
        chk("sb_done_stall", {31'd0, stall}, 32'd0);
        chk("sb_done_wdata", wdata, 32'd0);
        tick;
        idle_inputs;

        // Spurious rvalid in IDLE
        rvalid = 1; rdata = 32'h1234_5678;
        tick;
        rvalid = 0; settle;
        chk("idle_rv_load", load_data, 32'd0);
        chk("idle_rv_stall", {31'd0, stall}, 32'd0);

        // LB 0x2001, gnt after two waits, spurious rvalid in REQ
        set_load(32'h0000_2001, 2'b00, 0);
        gnt = 0; settle;
        chk("lb_req0", {31'd0, req}, 32'd1);
        chk("lb_be", {28'd0, be}, 32'h2);
        chk("lb_addr", addr, 32'h0000_2000);
        chk("lb_stall0", {31'd0, stall}, 32'd1);
        tick;                               // -> REQ
        mem_addr = 32'h0000_FFFF;           // holding register must win
        rvalid = 1; rdata = 32'h1234_5678; settle;
        chk("lb_req1_addr", addr, 32'h0000_2000);
        chk("lb_stall1", {31'd0, stall}, 32'd1);
        tick;                               // still REQ
        rvalid = 0; gnt = 1; settle;
        chk("lb_req2", {31'd0, req}, 32'd1);
        chk("lb_req_rv_load", load_data, 32'd0);
        chk("lb_stall2", {31'd0, stall}, 32'd1);
        tick;                               // -> RESP
        gnt = 0; rvalid = 1; rdata = 32'h0000_8000; settle;
        chk("lb_resp_req", {31'd0, req}, 32'd0);
        chk("lb_stall3", {31'd0, stall}, 32'd1);
        tick;                               // -> DONE
        rvalid = 0; settle;
        chk("lb_stall_done", {31'd0, stall}, 32'd0);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        tick;
        idle_inputs;

        quick_load("lbu", 32'h0000_2001, 2'b00, 1, 32'h0000_8000, 32'h0000_0080);
        quick_load("lh",  32'h0000_2002, 2'b01, 0, 32'h8001_1234, 32'hFFFF_8001);
        quick_load("lhu", 32'h0000_2002, 2'b01, 1, 32'h8001_1234, 32'h0000_8001);
        quick_load("lw",  32'h0000_2000, 2'b10, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // gnt and rvalid together in REQ: rvalid belongs to no request
        set_load(32'h0000_2000, 2'b10, 0);
        gnt = 0;
        tick;                               // -> REQ
        gnt = 1; rvalid = 1; rdata = 32'h1111_1111;
        tick;                               // -> RESP
        gnt = 0; rvalid = 0; settle;
        chk("gr_wait_stall", {31'd0, stall}, 32'd1);
        chk("gr_load_hold", load_data, 32'hDEAD_BEEF);
        tick;                               // RESP wait cycle
        rvalid = 1; rdata = 32'h2222_2222;
        tick;                               // -> DONE
        rvalid = 0; settle;
        chk("gr_data", load_data, 32'h2222_2222);
        chk("gr_stall_done", {31'd0, stall}, 32'd0);
        tick;
        idle_inputs;

        // Reset while in RESP
        set_load(32'h0000_2000, 2'b10, 0);
        gnt = 1;
        tick;                               // -> RESP
        gnt = 0; rst = 1;
        tick;                               // -> IDLE
        rst = 0; idle_inputs;
        rvalid = 1; rdata = 32'h3333_3333; settle;
        chk("rr_req", {31'd0, req}, 32'd0);
        chk("rr_stall", {31'd0, stall}, 32'd0);
        chk("rr_load", load_data, 32'd0);
        tick;
        rvalid = 0; settle;
        chk("rr_late_rv", load_data, 32'd0);

        // Misaligned LW 0x3002
        set_load(32'h0000_3002, 2'b10, 0);
        settle;
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_req", {31'd0, req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        gnt = 1;
        tick;
        gnt = 0; settle;
        chk("mis_stay_idle", {31'd0, req}, 32'd0);
        chk("mis_flag2", {31'd0, misalign}, 32'd1);
        idle_inputs; settle;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
`else
        chk("mis_flag", {31'd0, misalign}, 32'd0);
        chk("mis_req", {31'd0, req}, 32'd1);
        chk("mis_addr", addr, 32'h0000_3000);
        chk("mis_be", {28'd0, be}, 32'hF);
        gnt = 1;
        tick;                               // -> RESP
        gnt = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
        tick;                               // -> DONE
        rvalid = 0; settle;
        chk("mis_data", load_data, 32'hCAFE_F00D);
        tick;
        idle_inputs;
`endif
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
